// File: rtl/vl_pipe_rx_buf.sv
// ----------------------------------------------------------------------------
// vl_pipe_rx_buf
//
// Receive-end buffer for a fixed-latency data pipe that has no backpressure.
// Every valid beat that arrives at the far end of the pipe is captured into a
// BUF_DEPTH-entry FIFO. The FIFO is presented to a consumer over a valid/ready
// handshake. Each entry the consumer takes sends a one-cycle credit pulse back
// toward the transmitter. The transmitter starts with BUF_DEPTH credits, so the
// buffer cannot overflow in legal operation. The overflow flag is sticky and
// exists only to catch a misbehaving transmitter.
//
// Ports:
//   clk       rising-edge clock for all logic
//   reset_n   synchronous, active-low reset
//   clr       synchronous flush; empties the buffer without returning credits
//   in_vld    beat valid at the pipe output (always pushed, never stalled)
//   in_data   beat data
//   out_vld   buffer non-empty (registered)
//   out_data  head-of-FIFO data, show-ahead, combinational from storage
//   out_rdy   consumer takes the head when out_vld is high
//   crd_rtn   one-cycle credit pulse, one per popped entry, one cycle late
//   fill_lvl  current entry count, 0..BUF_DEPTH
//   ovf_err   sticky overflow flag, cleared by reset or clr
// ----------------------------------------------------------------------------
module vl_pipe_rx_buf #(
    parameter int PIPE_DW   = 8,
    parameter int BUF_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               in_vld,
    input  logic [PIPE_DW-1:0] in_data,
    output logic               out_vld,
    output logic [PIPE_DW-1:0] out_data,
    input  logic               out_rdy,
    output logic               crd_rtn,
    output logic [PTR_W:0]     fill_lvl,
    output logic               ovf_err
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PIPE_DW-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [PTR_W:0]     count_nxt;
    logic               vld_q;
    logic               crd_q;
    logic               ovf_q;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign push = in_vld;
    assign pop  = vld_q & out_rdy;

    // A full buffer can still accept a beat when the head leaves in the same
    // cycle, because that pop frees the slot being written.
    assign push_ok = push & ((count != FULL_CNT) | pop);
    assign drop    = push & ~push_ok;

    // Occupancy after this cycle. A push and a pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Control state. Reset and flush both return everything to empty. out_vld
    // is registered from the next count, so it is always equal to (count != 0)
    // and there is no same-cycle bypass from in_vld.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= 1'b0;
            crd_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            vld_q <= (count_nxt != '0);
            crd_q <= pop;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is not reset. A write is suppressed in reset and flush cycles so
    // that a beat arriving with clr is fully discarded.
    always_ff @(posedge clk) begin
        if (reset_n && !clr && push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = mem[rd_ptr];
    assign crd_rtn  = crd_q;
    assign fill_lvl = count;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_vl_pipe_rx_buf.sv
// ----------------------------------------------------------------------------
// tb_vl_pipe_rx_buf
//
// Self-checking bench for vl_pipe_rx_buf. A table of per-cycle records lists
// the inputs and the control outputs expected after the clock edge. Data
// ordering is tracked by a scoreboard queue: a beat is queued when it is
// driven and the buffer should accept it, and it is compared when the DUT
// hands an entry to the consumer. Streaming, flush and mid-traffic reset are
// written out as short hand sequences.
// ----------------------------------------------------------------------------
module tb_vl_pipe_rx_buf;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_rdy = 1'b0;
    logic       out_vld;
    logic [7:0] out_data;
    logic       crd_rtn;
    logic [2:0] fill_lvl;
    logic       ovf_err;

    typedef struct packed {
        logic       rn;
        logic       c;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_vld;
        logic [2:0] e_fill;
        logic       e_ovf;
        logic       e_crd;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    int         crd_count;

    vl_pipe_rx_buf #(
        .PIPE_DW  (8),
        .BUF_DEPTH(4),
        .PTR_W    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .in_vld  (in_vld),
        .in_data (in_data),
        .out_vld (out_vld),
        .out_data(out_data),
        .out_rdy (out_rdy),
        .crd_rtn (crd_rtn),
        .fill_lvl(fill_lvl),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rn, input logic c, input logic v, input logic [7:0] d,
                          input logic r, input logic ev, input logic [2:0] ef,
                          input logic eo, input logic ec);
        vecs.push_back(vec_t'{rn, c, v, d, r, ev, ef, eo, ec});
    endtask

    // Drive one cycle of inputs on the falling edge, score any handshake the
    // DUT makes, advance the reference queue, then step past the rising edge.
    task automatic applyStimulus(input logic rn, input logic c, input logic v,
                                 input logic [7:0] d, input logic r);
        bit full;
        bit m_pop;
        @(negedge clk);
        reset_n = rn;
        clr     = c;
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        #1;
        m_pop = (sb.size() != 0) && r;
        if (rn && !c && out_vld && out_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop_data: actual=%0h required=no entry", out_data);
            end else begin
                compare("pop_data", {24'h0, out_data}, {24'h0, sb[0]});
            end
        end
        if (!rn || c) begin
            sb.delete();
        end else begin
            full = (sb.size() == 4);
            if (m_pop) begin
                void'(sb.pop_front());
            end
            if (v && (!full || m_pop)) begin
                sb.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [2:0] ef,
                               input logic eo, input logic ec);
        compare({name, ".out_vld"},  {31'h0, out_vld},  {31'h0, ev});
        compare({name, ".fill_lvl"}, {29'h0, fill_lvl}, {29'h0, ef});
        compare({name, ".ovf_err"},  {31'h0, ovf_err},  {31'h0, eo});
        compare({name, ".crd_rtn"},  {31'h0, crd_rtn},  {31'h0, ec});
        if (ev && sb.size() != 0) begin
            compare({name, ".out_data"}, {24'h0, out_data}, {24'h0, sb[0]});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //     rn c  v  data   r  vld fill ovf crd
        // reset, single beat with consumer ready
        addVec(0, 0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
        addVec(1, 0, 1, 8'hA5, 1, 1, 3'd1, 0, 0);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1);
        addVec(1, 0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
        // fill to 4 while stalled, then drain with 4 back-to-back credits
        addVec(1, 0, 1, 8'h01, 0, 1, 3'd1, 0, 0);
        addVec(1, 0, 1, 8'h02, 0, 1, 3'd2, 0, 0);
        addVec(1, 0, 1, 8'h03, 0, 1, 3'd3, 0, 0);
        addVec(1, 0, 1, 8'h04, 0, 1, 3'd4, 0, 0);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd3, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd2, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd1, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 0);
        // full with simultaneous pop accepts the beat
        addVec(1, 0, 1, 8'h01, 0, 1, 3'd1, 0, 0);
        addVec(1, 0, 1, 8'h02, 0, 1, 3'd2, 0, 0);
        addVec(1, 0, 1, 8'h03, 0, 1, 3'd3, 0, 0);
        addVec(1, 0, 1, 8'h04, 0, 1, 3'd4, 0, 0);
        addVec(1, 0, 1, 8'h05, 1, 1, 3'd4, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd3, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd2, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd1, 0, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 0, 1);
        addVec(1, 0, 0, 8'h00, 0, 0, 3'd0, 0, 0);
        // full without pop drops the beat and sets the sticky flag
        addVec(1, 0, 1, 8'h01, 0, 1, 3'd1, 0, 0);
        addVec(1, 0, 1, 8'h02, 0, 1, 3'd2, 0, 0);
        addVec(1, 0, 1, 8'h03, 0, 1, 3'd3, 0, 0);
        addVec(1, 0, 1, 8'h04, 0, 1, 3'd4, 0, 0);
        addVec(1, 0, 1, 8'h06, 0, 1, 3'd4, 1, 0);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd3, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd2, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 1, 3'd1, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 3'd0, 1, 1);
        addVec(1, 0, 0, 8'h00, 0, 0, 3'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rn, vecs[i].c, vecs[i].v, vecs[i].d, vecs[i].r);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_fill,
                        vecs[i].e_ovf, vecs[i].e_crd);
        end

        // streaming push+pop across two pointer wraps; ovf_err is still set
        crd_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 1, 8'(16 + i), 1);
            if (crd_rtn) crd_count++;
            checkOutput($sformatf("stream%0d", i), 1, 3'd1, 1, (i != 0));
        end
        applyStimulus(1, 0, 0, 8'h00, 1);
        if (crd_rtn) crd_count++;
        checkOutput("stream_end", 0, 3'd0, 1, 1);
        compare("crd_total", crd_count, 32'd10);

        // flush with three entries held and a beat arriving in the same cycle
        applyStimulus(1, 0, 1, 8'h31, 0);
        checkOutput("preclr1", 1, 3'd1, 1, 0);
        applyStimulus(1, 0, 1, 8'h32, 0);
        checkOutput("preclr2", 1, 3'd2, 1, 0);
        applyStimulus(1, 0, 1, 8'h33, 0);
        checkOutput("preclr3", 1, 3'd3, 1, 0);
        applyStimulus(1, 1, 1, 8'h55, 1);
        checkOutput("clr", 0, 3'd0, 0, 0);
        applyStimulus(1, 0, 1, 8'h77, 0);
        checkOutput("post_clr_push", 1, 3'd1, 0, 0);

        // reset during active traffic
        applyStimulus(1, 0, 1, 8'h88, 0);
        checkOutput("pre_reset", 1, 3'd2, 0, 0);
        applyStimulus(0, 0, 1, 8'h99, 1);
        checkOutput("mid_reset", 0, 3'd0, 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("post_reset", 0, 3'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vl_pipe_rx_buf.md
Name: vl_pipe_rx_buf

Overview:
- Receive-end buffer for a fixed-latency, no-backpressure data pipe built from delay-line stages.
- Captures every valid beat arriving at the far end of the pipe into a BUF_DEPTH-entry FIFO and presents it to a consumer over a valid/ready handshake.
- Returns one credit pulse per consumed entry back toward the transmitter. The transmitter starts with BUF_DEPTH credits, so the buffer never overflows in legal operation.

Parameters:
- PIPE_DW, 8, data width of each beat.
- BUF_DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- PTR_W, 2, log2(BUF_DEPTH); pointer width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- clr  input  1  synchronous flush; empties the buffer.
- in_vld  input  1  beat valid at the pipe output.
- in_data  input  PIPE_DW  beat data.
- out_vld  output  1  buffer non-empty.
- out_data  output  PIPE_DW  head-of-FIFO data (show-ahead).
- out_rdy  input  1  consumer accepts the head when out_vld is high.
- crd_rtn  output  1  one-cycle credit pulse; one pulse per popped entry.
- fill_lvl  output  PTR_W+1  current entry count, 0..BUF_DEPTH.
- ovf_err  output  1  sticky overflow flag.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Pointers, count and fill_lvl go to 0.
  - out_vld, crd_rtn and ovf_err go to 0.
  - Storage array is not reset. out_data is don't-care while out_vld=0.
- Definitions:
  - push = in_vld.
  - pop = out_vld & out_rdy.
- State: wr_ptr, rd_ptr (PTR_W bits each, natural wrap at BUF_DEPTH), and count (PTR_W+1 bits).
- Push accepted when count<BUF_DEPTH, or when count==BUF_DEPTH and pop is high in the same cycle.
  - Accepted push writes mem[wr_ptr] and increments wr_ptr.
- Full and push without pop:
  - Beat is dropped; wr_ptr and mem are unchanged.
  - ovf_err is set and holds until reset or clr.
- Pop increments rd_ptr.
- Count update: push only → +1; pop only → -1; both → unchanged.
- out_vld = (count!=0), registered from count.
  - Latency in_vld → out_vld is 1 cycle when the buffer is empty.
  - There is no same-cycle bypass.
- out_data = mem[rd_ptr], combinational from the array. It is stable while out_vld=1 and out_rdy=0.
- fill_lvl = count.
- crd_rtn is registered and equals pop from the previous cycle.
  - Back-to-back pops give back-to-back pulses.
  - Total crd_rtn pulses always equal total pops.
- clr (reset_n=1):
  - Next cycle: count=0, pointers=0, out_vld=0, ovf_err=0, crd_rtn=0.
  - A push in the clr cycle is discarded.
  - No credits are returned for flushed entries. The transmitter must be cleared in the same cycle.
- reset_n=0 has priority over clr, and both have priority over push/pop.
- Reset mid-operation: all held beats are lost; the state after reset is the same as the reset state above.

Test Plan:
- Reset, then push a single beat 0xA5 with out_rdy=1 → out_vld=1 with 0xA5 one cycle later; pop that cycle; crd_rtn=1 the next cycle; fill_lvl returns to 0.
- Push 0x01..0x04 with out_rdy=0 → fill_lvl=4, out_data holds 0x01. Then raise out_rdy → pops 0x01..0x04 in order; crd_rtn pulses 4 consecutive cycles.
- Fill to 4, then push 0x05 with out_rdy=1 in the same cycle → 0x05 accepted, fill_lvl stays 4, ovf_err=0; drain order is 0x02,0x03,0x04,0x05.
- Fill to 4, then push 0x06 with out_rdy=0 → beat dropped, ovf_err=1 (sticky), fill_lvl=4; drain yields 0x01..0x04 only.
- Continuous push and pop for 10 beats (0x10..0x19), crossing pointer wrap twice → output order matches input, fill_lvl stays 1 after the first beat, 10 crd_rtn pulses total.
- With 3 entries held and ovf_err=1, assert clr together with in_vld → out_vld=0, fill_lvl=0, ovf_err=0, no crd_rtn pulses; the next push 0x77 appears 1 cycle later. Also assert reset_n=0 during active traffic → all outputs return to 0.
